// File: rtl/level_sensor_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// level_sensor_reader
//
// Front end of the irrigation display path. Each raw switch goes through a
// two-flop synchroniser and then a debouncer. The debounced tank-level switches
// are checked for a physically possible combination. The module then delivers
// registered m7/h/m/l flags to the segment decoders.
//
// An implausible tank reading forces a safe "tank empty" output (h=m=l=0), which
// inhibits the pump, and raises err until the reading has been plausible for
// RECOVER_CYCLES consecutive cycles.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-high
//   raw_m7     in   soil-moisture switch (1 = soil below threshold), asynchronous
//   raw_h      in   tank high-level switch (1 = water present), asynchronous
//   raw_m      in   tank mid-level switch (1 = water present), asynchronous
//   raw_l      in   tank low-level switch (1 = water present), asynchronous
//   m7         out  debounced moisture flag
//   h, m, l    out  validated tank-level flags
//   ready      out  1 once the initial settle period has elapsed
//   err        out  1 while the tank reading is in FAULT
//   fault_cnt  out  number of OK->FAULT entries, saturating at 255
// -----------------------------------------------------------------------------
module level_sensor_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RECOVER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_m7,
  input  logic       raw_h,
  input  logic       raw_m,
  input  logic       raw_l,
  output logic       m7,
  output logic       h,
  output logic       m,
  output logic       l,
  output logic       ready,
  output logic       err,
  output logic [7:0] fault_cnt
);

  localparam int NUM_IN = 4;
  localparam int IDX_L  = 0;
  localparam int IDX_M  = 1;
  localparam int IDX_H  = 2;
  localparam int IDX_M7 = 3;

  localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int ICW = $clog2(DEBOUNCE_CYCLES + 2) + 1;
  localparam int RCW = $clog2(RECOVER_CYCLES) + 1;

  // A debounced value flips when the counter already holds DEBOUNCE_CYCLES-1
  // and the mismatch is still present, so the mismatch has then lasted
  // DEBOUNCE_CYCLES cycles.
  localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(DEBOUNCE_CYCLES + 1);
  localparam logic [RCW-1:0] REC_LAST  = RCW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_OK    = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Legal tank states fill from the bottom up: {l,m,h} = 000, 100, 110, 111.
  function automatic logic plausible(input logic lv, input logic mv, input logic hv);
    logic res;
    case ({lv, mv, hv})
      3'b000, 3'b100, 3'b110, 3'b111: res = 1'b1;
      default:                        res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_IN-1:0] raw_vec;
  assign raw_vec = {raw_m7, raw_h, raw_m, raw_l};

  logic [NUM_IN-1:0] sync1_q, sync1_d;
  logic [NUM_IN-1:0] sync2_q, sync2_d;
  logic [NUM_IN-1:0] deb_q, deb_d;
  logic [DCW-1:0]    deb_cnt_q [NUM_IN];
  logic [DCW-1:0]    deb_cnt_d [NUM_IN];

  state_t            state_q, state_d;
  logic [ICW-1:0]    init_cnt_q, init_cnt_d;
  logic [RCW-1:0]    rec_cnt_q, rec_cnt_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              m7_q, m7_d;
  logic              h_q, h_d;
  logic              m_q, m_d;
  logic              l_q, l_d;
  logic              combo_ok;

  // ---- synchroniser stages ----
  always_comb begin
    sync1_d = raw_vec;
    sync2_d = sync1_q;
  end

  // ---- debounce stage ----
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_IN; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  assign combo_ok = plausible(deb_q[IDX_L], deb_q[IDX_M], deb_q[IDX_H]);

  // ---- FSM next state / counters ----
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rec_cnt_d   = rec_cnt_q;
    fault_cnt_d = fault_cnt_q;
    ready_d     = ready_q;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_cnt_d = '0;
          ready_d    = 1'b1;
          // Leaving INIT into FAULT is a start-up condition, not a fault entry.
          state_d    = combo_ok ? ST_OK : ST_FAULT;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      ST_OK: begin
        if (!combo_ok) begin
          state_d     = ST_FAULT;
          rec_cnt_d   = '0;
          fault_cnt_d = sat_inc8(fault_cnt_q);
        end
      end
      ST_FAULT: begin
        if (!combo_ok) begin
          rec_cnt_d = '0;
        end else if (rec_cnt_q == REC_LAST) begin
          rec_cnt_d = '0;
          state_d   = ST_OK;
        end else begin
          rec_cnt_d = rec_cnt_q + RCW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---- output register stage ----
  // Outputs follow the state being entered, so that err and the forced-empty
  // tank flags appear on the same edge as the FSM enters FAULT.
  always_comb begin
    m7_d  = 1'b0;
    h_d   = 1'b0;
    m_d   = 1'b0;
    l_d   = 1'b0;
    err_d = 1'b0;
    case (state_d)
      ST_OK: begin
        m7_d = deb_q[IDX_M7];
        h_d  = deb_q[IDX_H];
        m_d  = deb_q[IDX_M];
        l_d  = deb_q[IDX_L];
      end
      ST_FAULT: begin
        m7_d  = deb_q[IDX_M7];
        err_d = 1'b1;
      end
      default: begin
        m7_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rec_cnt_q   <= '0;
      fault_cnt_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      m7_q        <= 1'b0;
      h_q         <= 1'b0;
      m_q         <= 1'b0;
      l_q         <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      for (int i = 0; i < NUM_IN; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rec_cnt_q   <= rec_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      m7_q        <= m7_d;
      h_q         <= h_d;
      m_q         <= m_d;
      l_q         <= l_d;
    end
  end

  assign m7        = m7_q;
  assign h         = h_q;
  assign m         = m_q;
  assign l         = l_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign fault_cnt = fault_cnt_q;

endmodule
